fetch_seq: RTL
==============

Name: fetch_seq

Overview:
Program-counter sequencer and instruction-fetch controller for the RV32 core.
- Owns the architectural fetch PC and issues single-outstanding requests to instruction memory over a valid/ready port.
- Buffers one returned instruction for decode.
- Applies redirects from the exec-stage branch resolution unit: updates the PC, discards stale fetches and pulses a pipeline flush.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
INSTR_BYTES, 4, sequential PC increment in bytes (legal values 2 or 4)

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request this cycle
imem_req_addr  out  32  fetch address (current PC)
imem_rsp_valid  in  1  instruction returned this cycle
imem_rsp_data  in  32  returned instruction word
br_valid  in  1  exec stage has a resolved branch this cycle
br_taken  in  1  resolved branch is taken
br_target  in  32  redirect target from branch unit
stall  in  1  hazard unit freezes the IF/ID boundary
if_ready  in  1  decode can accept an instruction
if_valid  out  1  if_instr/if_pc valid
if_pc  out  32  PC of if_instr
if_instr  out  32  buffered instruction
flush_o  out  1  one-cycle pulse: kill IF/ID and ID/EX contents
misalign_o  out  1  one-cycle pulse: redirect target misaligned

Behaviour:
- Reset (rst_n low, async):
  - pc = RESET_PC, state = IDLE.
  - All outputs 0: if_pc = 0, if_instr = 0, imem_req_addr driven from pc.
- Outputs:
  - imem_req_valid is asserted only in FETCH and is combinational from state.
  - flush_o and misalign_o are registered, asserted the cycle after the redirect.
- "redirect" = br_valid && br_taken. br_valid with !br_taken has no effect.
- Redirect target:
  - Effective target = br_target with bit0 cleared (INSTR_BYTES=2) or bits[1:0] cleared (INSTR_BYTES=4).
  - If the cleared bits were nonzero, misalign_o pulses.
- PC arithmetic is 32-bit modulo 2^32. Example: 32'hFFFF_FFFC + 4 = 0.
- States:
  - IDLE: one cycle after reset release, then FETCH.
  - FETCH:
    - req_valid=1, addr=pc.
    - req_ready: latch issued_pc=pc, go to WAIT.
    - redirect without req_ready: pc=target, stay in FETCH. The address is allowed to change while unaccepted.
    - redirect with req_ready: pc=target, go to DRAIN.
  - WAIT: awaiting response, req_valid=0.
    - rsp_valid without redirect: if_instr=data, if_pc=issued_pc, if_valid=1, pc=issued_pc+INSTR_BYTES, go to HOLD.
    - redirect, with or without rsp_valid: the response (if any) is discarded, pc=target. Go to FETCH if rsp_valid was high, else DRAIN.
  - DRAIN: req_valid=0. The next rsp_valid is discarded, then FETCH.
    - Redirect in DRAIN updates pc=target and stays in DRAIN.
  - HOLD: if_valid=1 with if_instr/if_pc stable.
    - Hand-off occurs when if_ready && !stall: if_valid=0 next cycle, then FETCH.
    - redirect: if_valid=0 next cycle, pc=target, FETCH. Redirect takes priority over hand-off in the same cycle.
- Redirect and flush:
  - Every redirect, in any non-IDLE state, produces exactly one flush_o pulse. Back-to-back redirects give back-to-back pulses.
  - The last redirect's target wins.
- Throughput: at most one outstanding request, so the minimum is 3 cycles per instruction (FETCH, WAIT, HOLD) with zero-latency imem.
- rsp_valid in FETCH or HOLD is a protocol violation: ignored. Simulation-only assertion.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight response after reset is ignored until the first FETCH accept.

Decomposition:
- Shared package/defs header holds:
  - state encoding constants (IDLE, FETCH, WAIT, DRAIN, HOLD)
  - INSTR_BYTES legal values
  - a macro for target alignment masking, reused by the branch unit.
- One natural sub-module: fetch_buf, the 1-entry instruction/PC holding register with valid, load and clear. Everything else is flat in fetch_seq.

Test Plan:
1. Reset release, imem ready=1, rsp returned next cycle with 32'h0000_0013; if_ready=1 -> req addrs 0x0, 0x4, 0x8 in order; if_pc tracks them; if_instr=0x13.
2. stall=1 for 5 cycles while in HOLD at pc 0x8 -> if_valid held, if_instr stable; no req issued until stall drops.
3. Taken redirect to 0x100 while in WAIT (no rsp yet) -> DRAIN; late response discarded (if_valid stays 0); next req addr=0x100; flush_o pulses once.
4. Redirect to 0x200 in the same cycle as rsp_valid in WAIT -> response dropped, no DRAIN; next cycle FETCH addr=0x200; flush_o=1.
5. Redirect to 0x103 with INSTR_BYTES=4 -> misalign_o=1 and flush_o=1 one cycle; next req addr=0x100.
6. RESET_PC=32'hFFFF_FFFC, one sequential fetch -> next req addr=0x0. Additionally, rst_n asserted during WAIT -> all outputs 0 asynchronously; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared definitions for the fetch sequencer and branch unit
// Rev 1.0 - initial release
`default_nettype none

// Mask that clears the sub-instruction address bits of a fetch/branch target.
`ifndef FETCH_ALIGN_MASK
`define FETCH_ALIGN_MASK(bytes) (~(32'(bytes) - 32'd1))
`endif

package fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } fetch_state_e;

  localparam int unsigned IB_HALF = 2;
  localparam int unsigned IB_WORD = 4;

endpackage

`default_nettype wire

// File: rtl/fetch_buf.sv
// fetch_buf: one-entry instruction/PC holding register between IF and ID
// Rev 1.0 - initial release
`default_nettype none

module fetch_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  // Contents are kept on clear; only the valid flag drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_seq.sv
// fetch_seq: PC sequencer and single-outstanding instruction-fetch controller
// Rev 1.0 - initial release
`default_nettype none

module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned INSTR_BYTES = IB_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        stall,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        flush_o,
  output logic        misalign_o
);

  localparam logic [31:0] ALIGN_MASK = `FETCH_ALIGN_MASK(INSTR_BYTES);
  localparam logic [31:0] PC_STEP    = 32'(INSTR_BYTES);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  issued_pc, issued_pc_n;
  logic [31:0]  target;
  logic         redirect;
  logic         flush_n, misalign_n;
  logic         buf_load, buf_clear;

  assign redirect       = br_valid && br_taken;
  assign target         = br_target & ALIGN_MASK;
  assign imem_req_valid = (state == ST_FETCH);
  assign imem_req_addr  = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      issued_pc  <= '0;
      flush_o    <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      issued_pc  <= issued_pc_n;
      flush_o    <= flush_n;
      misalign_o <= misalign_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    issued_pc_n = issued_pc;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
    flush_n     = redirect && (state != ST_IDLE);
    misalign_n  = flush_n && (|(br_target & ~ALIGN_MASK));

    case (state)
      ST_IDLE: state_n = ST_FETCH;

      // An accepted request that coincides with a redirect is already stale.
      ST_FETCH: begin
        if (redirect) begin
          pc_n    = target;
          state_n = imem_req_ready ? ST_DRAIN : ST_FETCH;
        end else if (imem_req_ready) begin
          issued_pc_n = pc;
          state_n     = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redirect) begin
          pc_n    = target;
          state_n = imem_rsp_valid ? ST_FETCH : ST_DRAIN;
        end else if (imem_rsp_valid) begin
          buf_load = 1'b1;
          pc_n     = issued_pc + PC_STEP;
          state_n  = ST_HOLD;
        end
      end

      // Once the stale response lands nothing is outstanding, redirect or not.
      ST_DRAIN: begin
        if (redirect) begin
          pc_n = target;
        end
        if (imem_rsp_valid) begin
          state_n = ST_FETCH;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          buf_clear = 1'b1;
          pc_n      = target;
          state_n   = ST_FETCH;
        end else if (if_ready && !stall) begin
          buf_clear = 1'b1;
          state_n   = ST_FETCH;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  fetch_buf u_fetch_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_pc    (issued_pc),
    .load_instr (imem_rsp_data),
    .valid      (if_valid),
    .pc         (if_pc),
    .instr      (if_instr)
  );

  a_rsp_only_when_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (state == ST_FETCH || state == ST_HOLD))
  );

endmodule

`default_nettype wire
